// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 block encryptor: one round per clock, round keys expanded on the fly.
// Optional macro AES_ENC_LAST_KEY_EN adds lastkey_o, the final key window captured with data_o.

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Inverse computed as a^254 (0 maps to 0), followed by the affine transform.
   always_comb begin
      inv = a_i;
      for (int i = 0; i < 6; i++) inv = gfMul(gfMul(inv, inv), a_i);
      inv = gfMul(inv, inv);
      s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_enc_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [127:0]        data_i,
   input  logic [KEY_BITS-1:0] key_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [127:0]        data_o,
   output logic                valid_o,
   input  logic                ready_i
`ifdef AES_ENC_LAST_KEY_EN
   ,
   output logic [KEY_BITS-1:0] lastkey_o
`endif
);

   localparam int         NR       = (KEY_BITS == 256) ? 14 : 10;
   localparam logic [3:0] LAST_RND = 4'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : gBadKeyBits
      $error("aes_enc_iter: KEY_BITS must be 128 or 256, got %0d", KEY_BITS);
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t                fsmState_q;
   logic [127:0]        cipherState_q, cipherState_d;
   logic [KEY_BITS-1:0] keyWin_q, keyWin_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [3:0]          rndCnt_q;
   logic                ready_q;
   logic                valid_q;
   logic [127:0]        dataOut_q;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixColumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   logic [127:0] subState, shifted, mixed, roundKey;
   logic         lastRound;

   for (genvar k = 0; k < 16; k++) begin : gStateSbox
      aes_sbox uSbox (
         .a_i(cipherState_q[127-8*k -: 8]),
         .s_o(subState[127-8*k -: 8])
      );
   end

   // Byte k of the block is row k%4, column k/4; row r rotates left by r columns.
   always_comb begin
      shifted = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127-8*(4*c+r) -: 8] = subState[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) mixed[127-32*c -: 32] = mixColumn(shifted[127-32*c -: 32]);
   end

   assign lastRound     = (rndCnt_q == LAST_RND);
   assign cipherState_d = (lastRound ? shifted : mixed) ^ roundKey;

   logic        useRot;
   logic [31:0] lastWord, subIn, subOut, tWord;
   logic [31:0] n0, n1, n2, n3;
   logic [127:0] newWords;
   logic [7:0]  rconNext;

   assign lastWord = keyWin_q[31:0];
   assign subIn    = useRot ? {lastWord[23:0], lastWord[31:24]} : lastWord;

   for (genvar k = 0; k < 4; k++) begin : gKeySbox
      aes_sbox uSbox (
         .a_i(subIn[31-8*k -: 8]),
         .s_o(subOut[31-8*k -: 8])
      );
   end

   assign tWord    = subOut ^ (useRot ? {rcon_q, 24'h000000} : 32'h00000000);
   assign n0       = keyWin_q[KEY_BITS-1 -: 32] ^ tWord;
   assign n1       = keyWin_q[KEY_BITS-33 -: 32] ^ n0;
   assign n2       = keyWin_q[KEY_BITS-65 -: 32] ^ n1;
   assign n3       = keyWin_q[KEY_BITS-97 -: 32] ^ n2;
   assign newWords = {n0, n1, n2, n3};
   assign rconNext = xtime(rcon_q);

   if (KEY_BITS == 256) begin : gKey256
      // Round 1 uses the lower key half untouched; afterwards even rounds do the Rcon step, odd ones SubWord only.
      assign useRot   = ~rndCnt_q[0];
      assign roundKey = (rndCnt_q == 4'd1) ? keyWin_q[127:0] : newWords;
      assign keyWin_d = (rndCnt_q == 4'd1) ? keyWin_q : {keyWin_q[127:0], newWords};
      assign rcon_d   = rndCnt_q[0] ? rcon_q : rconNext;
   end else begin : gKey128
      assign useRot   = 1'b1;
      assign roundKey = newWords;
      assign keyWin_d = newWords;
      assign rcon_d   = rconNext;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsmState_q    <= IDLE;
         cipherState_q <= '0;
         keyWin_q      <= '0;
         rcon_q        <= 8'h00;
         rndCnt_q      <= 4'd0;
         ready_q       <= 1'b0;
         valid_q       <= 1'b0;
         dataOut_q     <= '0;
      end else begin
         case (fsmState_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (valid_i && ready_q) begin
                  cipherState_q <= data_i ^ key_i[KEY_BITS-1 -: 128];
                  keyWin_q      <= key_i;
                  rcon_q        <= 8'h01;
                  rndCnt_q      <= 4'd1;
                  ready_q       <= 1'b0;
                  fsmState_q    <= RUN;
               end
            end
            RUN: begin
               cipherState_q <= cipherState_d;
               keyWin_q      <= keyWin_d;
               rcon_q        <= rcon_d;
               rndCnt_q      <= rndCnt_q + 4'd1;
               if (lastRound) begin
                  dataOut_q  <= cipherState_d;
                  valid_q    <= 1'b1;
                  fsmState_q <= DONE;
               end
            end
            DONE: begin
               if (ready_i) begin
                  valid_q    <= 1'b0;
                  ready_q    <= 1'b1;
                  rndCnt_q   <= 4'd0;
                  fsmState_q <= IDLE;
               end
            end
            default: fsmState_q <= IDLE;
         endcase
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign data_o  = dataOut_q;

`ifdef AES_ENC_LAST_KEY_EN
   logic [KEY_BITS-1:0] lastKey_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lastKey_q <= '0;
      end else if (fsmState_q == RUN && lastRound) begin
         lastKey_q <= keyWin_d;
      end
   end

   assign lastkey_o = lastKey_q;
`endif

endmodule
